// File: rtl/booth_mult.sv
// rtl/booth_mult.sv - sequential signed radix-2 Booth multiplier with start/done handshake
//
// Purpose:
//   Multiplies two WIDTH-bit two's-complement operands into a 2*WIDTH-bit
//   product. It performs one Booth step per clock, so WIDTH steps per
//   operation. Operands are captured only on the edge that accepts start.
//
// Ports:
//   clk      in   1      rising-edge clock
//   rst      in   1      synchronous reset, active-high
//   start    in   1      launch request; accepted in IDLE or DONE
//   inbus1   in   WIDTH  multiplicand M (signed)
//   inbus2   in   WIDTH  multiplier Q (signed)
//   prod_hi  out  WIDTH  product[2*WIDTH-1:WIDTH]
//   prod_lo  out  WIDTH  product[WIDTH-1:0]
//   busy     out  1      high while in RUN
//   done     out  1      one-cycle pulse when the product is valid

module booth_mult #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] inbus1,
  input  logic [WIDTH-1:0] inbus2,
  output logic [WIDTH-1:0] prod_hi,
  output logic [WIDTH-1:0] prod_lo,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [4:0] LAST_STEP = 5'(WIDTH - 1);

  state_t           state_q, state_d;
  // The accumulator and multiplicand carry one extra sign bit. This lets
  // A - M stay representable when M is the most negative operand.
  logic [WIDTH:0]   a_q, a_d;
  logic [WIDTH:0]   m_q, m_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             qm1_q, qm1_d;
  logic [4:0]       count_q, count_d;

  logic [WIDTH:0]   step_sum;

  // Booth recoding on {Q[0], q_m1}: 01 adds M, 10 subtracts M, else no change.
  always_comb begin
    step_sum = a_q;
    case ({q_q[0], qm1_q})
      2'b01:   step_sum = a_q + m_q;
      2'b10:   step_sum = a_q - m_q;
      default: step_sum = a_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    m_d     = m_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    count_d = count_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          m_d     = {inbus1[WIDTH-1], inbus1};
          q_d     = inbus2;
          a_d     = '0;
          qm1_d   = 1'b0;
          count_d = '0;
          state_d = ST_RUN;
        end else if (state_q == ST_DONE) begin
          // Go back to IDLE. The product registers keep their values
          // until the next accepted start.
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        // Shift {A', Q, q_m1} arithmetically right by one. The msb of A'
        // is replicated.
        a_d     = {step_sum[WIDTH], step_sum[WIDTH:1]};
        q_d     = {step_sum[0], q_q[WIDTH-1:1]};
        qm1_d   = q_q[0];
        count_d = count_q + 5'd1;
        if (count_q == LAST_STEP) begin
          state_d = ST_DONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      m_q     <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      m_q     <= m_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      count_q <= count_d;
    end
  end

  assign prod_hi = a_q[WIDTH-1:0];
  assign prod_lo = q_q;
  assign busy    = (state_q == ST_RUN);
  assign done    = (state_q == ST_DONE);

endmodule

// File: tb/tb_booth_mult.sv
// tb/tb_booth_mult.sv - scoreboard testbench for booth_mult

module tb_booth_mult;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] inbus1;
  logic [15:0] inbus2;
  logic [15:0] prod_hi;
  logic [15:0] prod_lo;
  logic        busy;
  logic        done;

  typedef struct {
    logic [31:0] prod;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc;
  int   n_checks;
  int   n_fail;

  booth_mult #(.WIDTH(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .inbus1  (inbus1),
    .inbus2  (inbus2),
    .prod_hi (prod_hi),
    .prod_lo (prod_lo),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Compare each done pulse against the oldest queued expectation. The
  // expectation holds both the product and the cycle the pulse is due.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("product", {prod_hi, prod_lo}, e.prod);
        check("done_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Called just after a rising edge. Start is sampled on the next edge,
  // so the done pulse is due WIDTH edges later (cyc + 17). After the
  // start edge the inputs are scrambled, and this must not affect the
  // result.
  task automatic launch(input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    int   pa;
    int   pb;
    pa     = int'($signed(a));
    pb     = int'($signed(b));
    e.prod = 32'(pa * pb);
    e.cyc  = cyc + 17;
    sb.push_back(e);
    inbus1 = a;
    inbus2 = b;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    inbus1 = 16'($urandom);
    inbus2 = 16'($urandom);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 60; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
      #1;
    end
    check(tag, 32'(sb.size()), 32'd0);
    sb.delete();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    start    = 1'b0;
    inbus1   = 16'h0000;
    inbus2   = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_prod_hi", 32'(prod_hi), 32'd0);
    check("reset_prod_lo", 32'(prod_lo), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic small product, with busy and hold after completion.
    launch(16'h0003, 16'h0005);
    check("busy_after_start", 32'(busy), 32'd1);
    drain("drain_3x5");
    check("hold_prod", {prod_hi, prod_lo}, 32'h0000_000F);
    check("idle_busy", 32'(busy), 32'd0);

    launch(16'hFFF9, 16'h0006);
    drain("drain_m7x6");
    launch(16'h8000, 16'h8000);
    drain("drain_min_x_min");
    launch(16'h7FFF, 16'h8000);
    drain("drain_max_x_min");
    launch(16'h8000, 16'h7FFF);
    drain("drain_min_x_max");
    launch(16'hFFFF, 16'hFFFF);
    drain("drain_m1xm1");
    launch(16'h0000, 16'h8000);
    drain("drain_zero");

    // A start pulse during RUN must be ignored.
    launch(16'h0003, 16'h0005);
    repeat (4) @(posedge clk);
    #1;
    inbus1 = 16'h0009;
    inbus2 = 16'h0009;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    drain("drain_ignored_start");

    // Reset in the middle of RUN: the operation is aborted and no done pulse
    // appears.
    launch(16'h1234, 16'h5678);
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_prod", {prod_hi, prod_lo}, 32'd0);
    repeat (25) @(posedge clk);
    #1;
    launch(16'h0007, 16'hFFFD);
    drain("drain_after_abort");

    // Back-to-back: start is asserted during the DONE cycle.
    launch(16'h0003, 16'h0005);
    for (int i = 0; i < 40; i++) begin
      if (done) break;
      @(posedge clk);
      #1;
    end
    check("done_seen", 32'(done), 32'd1);
    launch(16'h0002, 16'hFFFE);
    drain("drain_back_to_back");

    // Random operands, some chained back-to-back.
    for (int n = 0; n < 12; n++) begin
      launch(16'($urandom), 16'($urandom));
      if (n % 3 != 2) begin
        for (int i = 0; i < 40; i++) begin
          if (done) break;
          @(posedge clk);
          #1;
        end
      end else begin
        drain("drain_random");
      end
    end
    drain("drain_random_tail");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
